// File: rtl/i2c_seq_ctrl.sv
// I2C transaction sequencer: turns one latched read/write command into a series of
// byte-engine handshakes (device address, register address, data, repeated start, stop).
module i2c_seq_ctrl #(
  parameter int MAX_BYTES = 4,
  parameter int REG_BYTES = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           req,
  output logic                                           ready,
  input  logic                                           rd_wr,
  input  logic [6:0]                                     dev_addr,
  input  logic [8*((REG_BYTES > 0) ? REG_BYTES : 1)-1:0] reg_addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0]                 len,
  input  logic [8*MAX_BYTES-1:0]                         wdata,
  output logic [8*MAX_BYTES-1:0]                         rdata,
  output logic                                           cmd_done,
  output logic                                           ack_err,
  output logic                                           eng_start,
  output logic                                           eng_rw,
  output logic                                           eng_rstart,
  output logic                                           eng_stop,
  output logic [7:0]                                     eng_tx_data,
  output logic                                           eng_sda_en,
  output logic                                           eng_rx_ack,
  input  logic                                           eng_busy,
  input  logic                                           eng_done,
  input  logic                                           eng_nack,
  input  logic [7:0]                                     eng_rx_data
);

  localparam int            LW       = $clog2(MAX_BYTES + 1);
  localparam int            RW       = (REG_BYTES > 0) ? REG_BYTES : 1;
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_BYTES);
  localparam logic [LW-1:0] REG_LAST = LW'(RW - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, REG, WDATA, RSTART, RADDR, RDATA, STOP, FIN
  } state_e;

  state_e                 state_q, state_d;
  logic                   rd_q, rd_d;
  logic [6:0]             dev_q, dev_d;
  logic [8*RW-1:0]        reg_q, reg_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          cnt_q, cnt_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
  logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
  logic                   ack_err_q, ack_err_d;
  logic                   wait_q, wait_d;    // handshake: 0 = requesting, 1 = waiting for busy low
  logic                   ackph_q, ackph_d;  // RDATA: 0 = receive byte, 1 = master ACK/NACK

  logic                   req_ph;
  logic                   cpl;
  logic                   last_byte;
  logic [8*RW-1:0]        reg_sh;
  logic [8*MAX_BYTES-1:0] wdata_sh;
  state_e                 after_reg;

  assign req_ph    = ~wait_q;
  assign cpl       = wait_q & ~eng_busy;
  assign last_byte = (cnt_q + 1'b1) == len_q;
  assign reg_sh    = reg_q << {cnt_q, 3'b000};
  assign wdata_sh  = wdata_q >> {cnt_q, 3'b000};
  assign after_reg = rd_q ? RSTART : ((len_q == '0) ? STOP : WDATA);

  assign ready   = (state_q == IDLE);
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

  always_comb begin
    // NOTE: every signal written below gets a default first so no path infers a latch.
    state_d     = state_q;
    rd_d        = rd_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_err_d   = ack_err_q;
    wait_d      = wait_q;
    ackph_d     = ackph_q;
    cmd_done    = 1'b0;
    eng_start   = 1'b0;
    eng_rw      = 1'b0;
    eng_rstart  = 1'b0;
    eng_stop    = 1'b0;
    eng_tx_data = 8'h00;
    eng_sda_en  = 1'b0;
    eng_rx_ack  = 1'b0;

    if (state_q inside {ADDR, REG, WDATA, RSTART, RADDR, RDATA}) begin
      if (req_ph && eng_busy) wait_d = 1'b1;
      if (cpl)                wait_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (req) begin
          rd_d      = rd_wr;
          dev_d     = dev_addr;
          reg_d     = reg_addr;
          wdata_d   = wdata;
          len_d     = (len > LEN_MAX) ? LEN_MAX : len;
          ack_err_d = 1'b0;
          cnt_d     = '0;
          wait_d    = 1'b0;
          ackph_d   = 1'b0;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        eng_start = req_ph;
        if (req_ph) eng_tx_data = {dev_q, (REG_BYTES == 0) && rd_q};
        if (cpl) begin
          cnt_d = '0;
          if (eng_nack) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (REG_BYTES > 0) begin
            state_d = REG;
          end else if (rd_q) begin
            // Without a register phase the read address goes out here directly.
            state_d = (len_q == '0) ? STOP : RDATA;
          end else begin
            state_d = after_reg;
          end
        end
      end

      REG: begin
        eng_start = req_ph;
        if (req_ph) eng_tx_data = reg_sh[8*RW-1 -: 8];
        if (cpl) begin
          if (eng_nack) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (cnt_q == REG_LAST) begin
            cnt_d   = '0;
            state_d = after_reg;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WDATA: begin
        eng_start = req_ph;
        if (req_ph) eng_tx_data = wdata_sh[7:0];
        if (cpl) begin
          if (eng_nack) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (last_byte) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RSTART: begin
        eng_start  = req_ph;
        eng_rstart = req_ph;
        if (cpl) begin
          cnt_d   = '0;
          state_d = RADDR;
        end
      end

      RADDR: begin
        eng_start = req_ph;
        if (req_ph) eng_tx_data = {dev_q, 1'b1};
        if (cpl) begin
          cnt_d = '0;
          if (eng_nack) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            state_d = (len_q == '0) ? STOP : RDATA;
          end
        end
      end

      RDATA: begin
        eng_start = req_ph;
        if (!ackph_q) begin
          eng_rw = req_ph;
          if (cpl) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (cnt_q == LW'(i)) rdata_d[8*i +: 8] = eng_rx_data;
            end
            ackph_d = 1'b1;
          end
        end else begin
          // NACK the final byte so the slave releases SDA before the stop.
          eng_sda_en = req_ph;
          eng_rx_ack = req_ph & last_byte;
          if (cpl) begin
            ackph_d = 1'b0;
            if (last_byte) state_d = STOP;
            else           cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        eng_stop = 1'b1;
        if (eng_done) state_d = FIN;
      end

      FIN: begin
        cmd_done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      // NOTE: the read-data register array is cleared by reset because it is visible on a port.
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      wait_q    <= 1'b0;
      ackph_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      wait_q    <= wait_d;
      ackph_q   <= ackph_d;
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Bench for i2c_seq_ctrl: a behavioural byte engine logs every handshake, and a
// transaction-level model predicts the event list, ack_err and rdata.
module tb_i2c_seq_ctrl;

  localparam int MAXB    = 4;
  localparam int EV_TX   = 1;
  localparam int EV_RS   = 2;
  localparam int EV_RX   = 3;
  localparam int EV_ACK  = 4;
  localparam int EV_STOP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd_wr;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic [2:0]  len;
  logic [31:0] wdata;

  logic        a_req, a_ready, a_cmd_done, a_ack_err;
  logic [31:0] a_rdata;
  logic        a_start, a_rw, a_rstart, a_stop, a_sda_en, a_rx_ack;
  logic [7:0]  a_txd, a_rxd;
  logic        a_busy, a_done, a_nack;

  logic        b_req, b_ready, b_cmd_done, b_ack_err;
  logic [31:0] b_rdata;
  logic        b_start, b_rw, b_rstart, b_stop, b_sda_en, b_rx_ack;
  logic [7:0]  b_txd, b_rxd;
  logic        b_busy, b_done, b_nack;

  i2c_seq_ctrl #(.MAX_BYTES(MAXB), .REG_BYTES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .ready(a_ready), .rd_wr(rd_wr),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .len(len), .wdata(wdata), .rdata(a_rdata),
    .cmd_done(a_cmd_done), .ack_err(a_ack_err), .eng_start(a_start), .eng_rw(a_rw),
    .eng_rstart(a_rstart), .eng_stop(a_stop), .eng_tx_data(a_txd), .eng_sda_en(a_sda_en),
    .eng_rx_ack(a_rx_ack), .eng_busy(a_busy), .eng_done(a_done), .eng_nack(a_nack),
    .eng_rx_data(a_rxd)
  );

  i2c_seq_ctrl #(.MAX_BYTES(MAXB), .REG_BYTES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .ready(b_ready), .rd_wr(rd_wr),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .len(len), .wdata(wdata), .rdata(b_rdata),
    .cmd_done(b_cmd_done), .ack_err(b_ack_err), .eng_start(b_start), .eng_rw(b_rw),
    .eng_rstart(b_rstart), .eng_stop(b_stop), .eng_tx_data(b_txd), .eng_sda_en(b_sda_en),
    .eng_rx_ack(b_rx_ack), .eng_busy(b_busy), .eng_done(b_done), .eng_nack(b_nack),
    .eng_rx_data(b_rxd)
  );

  int          checks = 0;
  int          errors = 0;
  int          nack_at = -1;
  logic [7:0]  rx_tab[16];
  logic [11:0] ev_a[$];
  logic [11:0] ev_b[$];
  logic [11:0] exp_q[$];
  logic [31:0] rmdl_a = '0;
  logic [31:0] rmdl_b = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int         st;
    int         cnt;
    int         txn;
    int         rxn;
    bit         pend;
    logic       busy;
    logic       done;
    logic       nack;
    logic [7:0] rx;
  } eng_t;

  // One negedge step of a byte engine with random start/busy/done latencies.
  task automatic eng_step(input logic rst, input logic st_i, input logic rw, input logic rs,
                          input logic sp, input logic sda, input logic rack,
                          input logic [7:0] txd, inout eng_t e,
                          output int ev, output logic [7:0] evd);
    ev = 0; evd = 8'h00; e.nack = 1'b0; e.done = 1'b0;
    if (!rst) begin
      e.st = 0; e.busy = 1'b0; e.txn = 0; e.rxn = 0; e.pend = 1'b0;
      return;
    end
    case (e.st)
      0: begin
        if (sp) begin
          ev = EV_STOP; e.st = 4; e.cnt = int'($urandom_range(2, 0)); e.txn = 0; e.rxn = 0;
        end else if (st_i) begin
          e.pend = 1'b0;
          if (sda) begin
            ev = EV_ACK; evd = {7'd0, rack};
          end else if (rs) begin
            ev = EV_RS;
          end else if (rw) begin
            ev = EV_RX; e.rx = rx_tab[e.rxn]; evd = e.rx; e.rxn++;
          end else begin
            ev = EV_TX; evd = txd; e.pend = (e.txn == nack_at); e.txn++;
          end
          e.st = 1; e.cnt = int'($urandom_range(2, 0));
        end
      end
      1: if (e.cnt == 0) begin e.busy = 1'b1; e.st = 2; e.cnt = int'($urandom_range(2, 0)); end
         else e.cnt--;
      2: if (e.cnt == 0) begin e.busy = 1'b0; e.nack = e.pend; e.st = 0; end
         else e.cnt--;
      4: if (e.cnt == 0) begin e.done = 1'b1; e.st = 0; end
         else e.cnt--;
      default: e.st = 0;
    endcase
  endtask

  initial begin
    eng_t ea; int ev; logic [7:0] evd;
    ea = '{default: 0};
    a_busy = 1'b0; a_done = 1'b0; a_nack = 1'b0; a_rxd = 8'h00;
    forever begin
      @(negedge clk);
      eng_step(rst_n, a_start, a_rw, a_rstart, a_stop, a_sda_en, a_rx_ack, a_txd, ea, ev, evd);
      a_busy = ea.busy; a_done = ea.done; a_nack = ea.nack; a_rxd = ea.rx;
      if (ev != 0) ev_a.push_back({ev[3:0], evd});
    end
  end

  initial begin
    eng_t eb; int ev; logic [7:0] evd;
    eb = '{default: 0};
    b_busy = 1'b0; b_done = 1'b0; b_nack = 1'b0; b_rxd = 8'h00;
    forever begin
      @(negedge clk);
      eng_step(rst_n, b_start, b_rw, b_rstart, b_stop, b_sda_en, b_rx_ack, b_txd, eb, ev, evd);
      b_busy = eb.busy; b_done = eb.done; b_nack = eb.nack; b_rxd = eb.rx;
      if (ev != 0) ev_b.push_back({ev[3:0], evd});
    end
  end

  // Transaction-level expectation: list of bytes on the bus, where the nack cuts it short.
  task automatic model(input int rbytes, input logic rd, input logic [6:0] dev,
                       input logic [7:0] ra, input int ln, input logic [31:0] wd,
                       input int nk, inout logic [31:0] rm, output logic aerr);
    logic [7:0] tx[$];
    int n;
    n = (ln > MAXB) ? MAXB : ln;
    exp_q.delete();
    aerr = 1'b0;
    tx.push_back({dev, rd && (rbytes == 0)});
    if (rbytes > 0) tx.push_back(ra);
    if (!rd) for (int i = 0; i < n; i++) tx.push_back(wd[8*i +: 8]);
    foreach (tx[i]) begin
      exp_q.push_back({4'(EV_TX), tx[i]});
      if (i == nk) begin
        aerr = 1'b1;
        exp_q.push_back({4'(EV_STOP), 8'h00});
        return;
      end
    end
    if (rd && rbytes > 0) begin
      exp_q.push_back({4'(EV_RS), 8'h00});
      exp_q.push_back({4'(EV_TX), dev, 1'b1});
      if (tx.size() == nk) begin
        aerr = 1'b1;
        exp_q.push_back({4'(EV_STOP), 8'h00});
        return;
      end
    end
    if (rd) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({4'(EV_RX), rx_tab[i]});
        exp_q.push_back({4'(EV_ACK), 7'd0, (i == n - 1)});
        rm[8*i +: 8] = rx_tab[i];
      end
    end
    exp_q.push_back({4'(EV_STOP), 8'h00});
  endtask

  task automatic run_txn(input bit inst, input logic rd, input logic [6:0] dev,
                         input logic [7:0] ra, input int ln, input logic [31:0] wd,
                         input int nk, output logic got_err, output int got_nev);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [11:0] got[$];
    bit          seen;
    nack_at = nk;
    exp_rd  = inst ? rmdl_b : rmdl_a;
    model(inst ? 0 : 1, rd, dev, ra, ln, wd, nk, exp_rd, exp_err);
    if (inst) rmdl_b = exp_rd; else rmdl_a = exp_rd;
    got_err = 1'bx;
    @(negedge clk);
    ev_a.delete(); ev_b.delete();
    check("ready_idle", inst ? b_ready : a_ready, 1'b1);
    rd_wr = rd; dev_addr = dev; reg_addr = ra; len = 3'(ln); wdata = wd;
    if (inst) b_req = 1'b1; else a_req = 1'b1;
    @(negedge clk);
    // req stays high one more cycle with fresh inputs: must be ignored while busy.
    rd_wr = 1'($urandom); dev_addr = 7'($urandom); reg_addr = 8'($urandom);
    len = 3'($urandom); wdata = $urandom;
    check("ready_busy", inst ? b_ready : a_ready, 1'b0);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (inst ? b_cmd_done : a_cmd_done) seen = 1'b1;
      else @(negedge clk);
    end
    check("cmd_done_timeout", seen, 1'b1);
    got_err = inst ? b_ack_err : a_ack_err;
    check("ack_err", got_err, exp_err);
    @(negedge clk);
    check("cmd_done_pulse", inst ? b_cmd_done : a_cmd_done, 1'b0);
    check("ready_after", inst ? b_ready : a_ready, 1'b1);
    check("ack_err_held", inst ? b_ack_err : a_ack_err, exp_err);
    if (inst) got = ev_b; else got = ev_a;
    got_nev = got.size();
    check("ev_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("ev%0d", i), got[i], exp_q[i]);
    check("rdata", inst ? b_rdata : a_rdata, exp_rd);
  endtask

  typedef struct {
    bit          inst;
    logic        rd;
    logic [6:0]  dev;
    logic [7:0]  ra;
    int          ln;
    logic [31:0] wd;
    int          nk;
    logic        exp_err;
    int          exp_nev;
    bit          chk_rd;
    logic [15:0] rd16;
  } vec_t;

  initial begin
    vec_t tab[13];
    logic gerr;
    int   gnev;
    bit   stop_seen;

    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    rd_wr = 1'b0; dev_addr = '0; reg_addr = '0; len = '0; wdata = '0;
    for (int i = 0; i < 16; i++) rx_tab[i] = 8'($urandom);
    rx_tab[0] = 8'h12; rx_tab[1] = 8'h34; rx_tab[2] = 8'h56; rx_tab[3] = 8'h78;
    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 1'b1);
    check("rst_cmd_done", a_cmd_done, 1'b0);
    check("rst_ack_err", a_ack_err, 1'b0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_eng", {a_start, a_rw, a_rstart, a_stop, a_sda_en, a_rx_ack, a_txd}, 14'h0);
    check("rst_ready_b", b_ready, 1'b1);
    rst_n = 1'b1;

    //           inst rd    dev     ra     ln wd            nk err   nev chk rd16
    tab[0]  = '{0, 1'b0, 7'h50, 8'h10, 2, 32'h0000BBAA, -1, 1'b0, 5,  0, 16'h0};
    tab[1]  = '{0, 1'b1, 7'h50, 8'h10, 2, 32'h0,        -1, 1'b0, 9,  1, 16'h3412};
    tab[2]  = '{0, 1'b0, 7'h50, 8'h10, 2, 32'h0000BBAA,  0, 1'b1, 2,  0, 16'h0};
    tab[3]  = '{0, 1'b0, 7'h50, 8'h10, 7, 32'h44332211, -1, 1'b0, 7,  0, 16'h0};
    tab[4]  = '{0, 1'b1, 7'h2A, 8'h33, 7, 32'h0,        -1, 1'b0, 13, 1, 16'h3412};
    tab[5]  = '{0, 1'b0, 7'h50, 8'h10, 0, 32'h0,        -1, 1'b0, 3,  0, 16'h0};
    tab[6]  = '{0, 1'b1, 7'h50, 8'h10, 0, 32'h0,        -1, 1'b0, 5,  1, 16'h3412};
    tab[7]  = '{0, 1'b1, 7'h50, 8'h10, 2, 32'h0,         1, 1'b1, 3,  0, 16'h0};
    tab[8]  = '{0, 1'b1, 7'h50, 8'h10, 2, 32'h0,         2, 1'b1, 5,  0, 16'h0};
    tab[9]  = '{1, 1'b1, 7'h50, 8'h00, 0, 32'h0,        -1, 1'b0, 2,  0, 16'h0};
    tab[10] = '{1, 1'b1, 7'h50, 8'h00, 1, 32'h0,        -1, 1'b0, 4,  1, 16'h0012};
    tab[11] = '{1, 1'b0, 7'h50, 8'h00, 1, 32'h000000CC, -1, 1'b0, 3,  0, 16'h0};
    tab[12] = '{0, 1'b0, 7'h50, 8'h10, 3, 32'h00332211,  3, 1'b1, 5,  0, 16'h0};

    foreach (tab[i]) begin
      run_txn(tab[i].inst, tab[i].rd, tab[i].dev, tab[i].ra, tab[i].ln, tab[i].wd,
              tab[i].nk, gerr, gnev);
      check($sformatf("tab%0d_ack_err", i), gerr, tab[i].exp_err);
      check($sformatf("tab%0d_ev_count", i), gnev, tab[i].exp_nev);
      if (tab[i].chk_rd)
        check($sformatf("tab%0d_rdata16", i),
              tab[i].inst ? b_rdata[15:0] : a_rdata[15:0], tab[i].rd16);
    end

    // Reset in the middle of a write: abort at once, no stop, then a clean transaction.
    nack_at = -1;
    @(negedge clk);
    ev_a.delete();
    rd_wr = 1'b0; dev_addr = 7'h50; reg_addr = 8'h10; len = 3'd4; wdata = 32'hDDCCBBAA;
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    for (int c = 0; c < 500 && ev_a.size() < 3; c++) @(negedge clk);
    check("rst_mid_reached_wdata", ev_a.size() >= 3, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", a_ready, 1'b1);
    check("rst_mid_eng", {a_start, a_rw, a_rstart, a_stop, a_sda_en, a_rx_ack, a_txd}, 14'h0);
    check("rst_mid_cmd_done", a_cmd_done, 1'b0);
    check("rst_mid_rdata", a_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rmdl_a = '0; rmdl_b = '0;
    repeat (4) @(negedge clk);
    stop_seen = 1'b0;
    foreach (ev_a[i]) if (ev_a[i][11:8] == 4'(EV_STOP)) stop_seen = 1'b1;
    check("rst_mid_no_stop", stop_seen, 1'b0);
    run_txn(0, 1'b0, 7'h50, 8'h10, 2, 32'h0000BBAA, -1, gerr, gnev);
    check("rst_after_ack_err", gerr, 1'b0);
    check("rst_after_ev_count", gnev, 5);

    // Randomised transactions against the model.
    for (int t = 0; t < 40; t++) begin
      bit inst;
      int nk;
      for (int i = 0; i < 16; i++) rx_tab[i] = 8'($urandom);
      inst = ($urandom_range(3, 0) == 0);
      nk   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 0)) : -1;
      run_txn(inst, 1'($urandom), 7'($urandom), 8'($urandom), int'($urandom_range(7, 0)),
              $urandom, nk, gerr, gnev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_seq_ctrl.md
I2C_SEQ_CTRL -- requirements
Module: i2c_seq_ctrl

Interface
REQ-001 SHALL provide parameter MAX_BYTES, default 4, the maximum number of data bytes per transaction (1..16).
REQ-002 SHALL provide parameter REG_BYTES, default 1, the register-address bytes sent after the device address (0..2).
REQ-003 SHALL provide clk  input  1  clock; all logic on posedge clk.
REQ-004 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide req  input  1  transaction request; accepted only when ready=1.
REQ-006 SHALL provide ready  output  1  high in IDLE only.
REQ-007 SHALL provide rd_wr  input  1  transaction direction: 1 = read, 0 = write.
REQ-008 SHALL provide dev_addr  input  7  7-bit device address.
REQ-009 SHALL provide reg_addr  input  8*REG_BYTES (min 1)  register address, MSB byte first.
REQ-010 SHALL provide len  input  $clog2(MAX_BYTES+1)  data byte count.
REQ-011 SHALL provide wdata  input  8*MAX_BYTES  write bytes; byte i = wdata[8i+:8], byte 0 sent first.
REQ-012 SHALL provide rdata  output  8*MAX_BYTES  read bytes; byte i stored at rdata[8i+:8].
REQ-013 SHALL provide cmd_done  output  1  one-cycle pulse at transaction end.
REQ-014 SHALL provide ack_err  output  1  slave NACK seen; valid with cmd_done, held until next accept.
REQ-015 SHALL provide eng_start, eng_rw, eng_rstart, eng_stop  output  1 each  byte-engine controls.
REQ-016 SHALL provide eng_tx_data  output  8  byte to transmit.
REQ-017 SHALL provide eng_sda_en, eng_rx_ack  output  1 each  master ACK/NACK drive after a read byte (eng_rx_ack: 0 = ACK, 1 = NACK).
REQ-018 SHALL provide eng_busy, eng_done, eng_nack  input  1 each; eng_rx_data  input  8.

Function
REQ-019 SHALL latch rd_wr, dev_addr, reg_addr, wdata and len on the cycle req=1 with ready=1; later input changes SHALL have no effect until the next accept.
REQ-020 SHALL clamp a latched len greater than MAX_BYTES to MAX_BYTES.
REQ-021 SHALL implement the byte handshake as follows:
- hold eng_start=1 with stable eng_rw and eng_tx_data until eng_busy=1;
- then wait for eng_busy=0; the byte completes on the first cycle eng_busy=0.
REQ-022 SHALL sample eng_nack on the byte-completion cycle of every transmitted byte, and eng_rx_data on the completion cycle of every received byte.
REQ-023 SHALL implement FSM states IDLE, ADDR, REG, WDATA, RSTART, RADDR, RDATA, STOP, FIN.
REQ-024 SHALL, on accept, go IDLE->ADDR and send {dev_addr, 0}; if REG_BYTES=0 and rd_wr=1, it SHALL instead send {dev_addr, 1} and go to RDATA.
REQ-025 SHALL, in REG, send REG_BYTES bytes MSB first.
REQ-026 SHALL, after REG, go to WDATA for writes and to RSTART for reads.
REQ-027 SHALL, in WDATA, send len bytes, then go to STOP; a write with len=0 SHALL go directly to STOP.
REQ-028 SHALL, in RSTART, assert eng_rstart=1 together with eng_start, using the same handshake, then go to RADDR.
REQ-029 SHALL, in RADDR, send {dev_addr, 1} and then go to RDATA.
REQ-030 SHALL, in RDATA, handle each byte with eng_rw=1, then a master ACK phase (eng_sda_en=1, eng_start=1) using the REQ-021 handshake:
- eng_rx_ack=0 for every byte except the last;
- eng_rx_ack=1 on the last byte.
REQ-031 SHALL treat a read with len=0 as an address probe: no RDATA phase, straight to STOP.
REQ-032 SHALL, on eng_nack=1 at any transmitted-byte completion, set ack_err=1, abandon remaining bytes and go to STOP.
REQ-033 SHALL, in STOP, hold eng_stop=1 until eng_done=1, then go to FIN.
REQ-034 SHALL, in FIN, pulse cmd_done for one cycle and return to IDLE.
REQ-035 SHALL use a byte counter of width $clog2(MAX_BYTES+1) that is reset at each phase entry and never wraps.
REQ-036 SHALL leave rdata bytes with index >= the number actually received unchanged from the previous transaction.
REQ-037 SHALL drive all eng_* outputs to 0 and eng_tx_data to 8'h00 in any state or cycle not specified above.
REQ-038 SHALL ignore req=1 while ready=0 (no queuing).

Reset
REQ-039 SHALL, while rst_n=0 at posedge clk, force the FSM to IDLE, ready=1, cmd_done=0, ack_err=0, rdata=0 and all eng_* outputs=0.
REQ-040 SHALL, on reset mid-transaction, abort immediately without issuing STOP.

Verification
REQ-041 SHALL verify a write with REG_BYTES=1, dev_addr=7'h50, reg_addr=8'h10, len=2, wdata=16'hBBAA -> tx sequence A0,10,AA,BB, then stop, cmd_done=1, ack_err=0.
REQ-042 SHALL verify a read with len=2, slave returning 8'h12 then 8'h34 -> tx A0,10; rstart; tx A1; rx_ack sequence 0 then 1; rdata[15:0]=16'h3412.
REQ-043 SHALL verify a NACK on the address byte -> no further bytes sent, stop issued, ack_err=1 with cmd_done.
REQ-044 SHALL verify a read probe with len=0 and REG_BYTES=0 -> tx A1 only, then stop, cmd_done.
REQ-045 SHALL verify len=7 with MAX_BYTES=4 -> exactly 4 data bytes transferred.
REQ-046 SHALL verify rst_n low during WDATA -> next cycle IDLE, ready=1, no eng_stop, and a following req completes normally.
